// File: rtl/fcnn_pkg.sv
// Shared types and sizing constants for the fully-connected network datapath.
package fcnn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int N_PIXELS   = 784;
  localparam int N_HIDDEN   = 30;
  localparam int N_OUT      = 10;

  typedef logic [DATA_WIDTH-1:0] pixel_t;
  typedef pixel_t [N_PIXELS-1:0] frame_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    FULL  = 2'd2
  } loader_state_t;

endpackage

// File: rtl/fcnn_frame_loader.sv
// Frame loader: collects pixels from a ready/valid stream into a wide frame
// register, presents it to the network until acknowledged, and discards
// malformed frames (early or missing last marker) with a one-cycle error pulse.
module fcnn_frame_loader
  import fcnn_pkg::*;
#(
  parameter int dataWidth = DATA_WIDTH,
  parameter int NoPixels  = N_PIXELS,
  parameter int CntWidth  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [dataWidth-1:0]                s_data,
  input  logic                                s_last,
  output logic [NoPixels-1:0][dataWidth-1:0]  frame_data,
  output logic                                frame_valid,
  input  logic                                frame_ack,
  output logic                                err_short,
  output logic                                err_long,
  output logic [CntWidth-1:0]                 frame_count
);

  localparam int                 IdxWidth = $clog2(NoPixels);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NoPixels - 1);

  loader_state_t                      r_state;
  logic [IdxWidth-1:0]                r_idx;
  logic [NoPixels-1:0][dataWidth-1:0] r_frame;
  logic                               r_valid;
  logic                               r_err_short;
  logic                               r_err_long;
  logic [CntWidth-1:0]                r_count;

  logic w_accept;
  logic w_wr_en;

  // Ready is held low through reset so no beat can be taken while state is undefined.
  assign s_ready  = !rst && (r_state != FULL);
  assign w_accept = s_valid && s_ready;
  // Only FILL writes the buffer; DRAIN beats are thrown away.
  assign w_wr_en  = w_accept && (r_state == FILL);

  assign frame_data  = r_frame;
  assign frame_valid = r_valid;
  assign err_short   = r_err_short;
  assign err_long    = r_err_long;
  assign frame_count = r_count;

  // Decoded-write pixel buffer: each element loads only when the fill index selects it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= '0;
    end else begin
      for (int i = 0; i < NoPixels; i++) begin
        if (w_wr_en && (r_idx == IdxWidth'(i))) begin
          r_frame[i] <= s_data;
        end
      end
    end
  end

  // Frame-assembly FSM with registered valid, error pulses and delivered-frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FILL;
      r_idx       <= '0;
      r_valid     <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_count     <= '0;
    end else begin
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (r_idx == LastIdx) begin
              r_idx <= '0;
              if (s_last) begin
                r_state <= FULL;
                r_valid <= 1'b1;
                r_count <= r_count + CntWidth'(1);
              end else begin
                // Too many pixels: skip the rest of this frame up to its marker.
                r_err_long <= 1'b1;
                r_state    <= DRAIN;
              end
            end else if (s_last) begin
              // Marker came early: restart at pixel 0, stale data gets overwritten.
              r_err_short <= 1'b1;
              r_idx       <= '0;
            end else begin
              r_idx <= r_idx + IdxWidth'(1);
            end
          end
        end
        DRAIN: begin
          if (w_accept && s_last) begin
            r_state <= FILL;
          end
        end
        FULL: begin
          // Requiring valid means a held ack can only retire the frame once.
          if (frame_ack && r_valid) begin
            r_state <= FILL;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcnn_frame_loader.sv
// Directed scoreboard bench for the frame loader: nominal, backpressure,
// short/long frames, asynchronous reset mid-fill and held-ack counter wrap.
module tb_fcnn_frame_loader;
  import fcnn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: default counter width.
  logic a_valid, a_ready, a_last, a_ack, a_fv, a_es, a_el;
  pixel_t a_data;
  frame_t a_frame;
  logic [15:0] a_cnt;

  // Instance B: 2-bit counter for the wrap test.
  logic b_valid, b_ready, b_last, b_ack, b_fv, b_es, b_el;
  pixel_t b_data;
  frame_t b_frame;
  logic [1:0] b_cnt;

  fcnn_frame_loader #(.dataWidth(16), .NoPixels(784), .CntWidth(16)) dut (
    .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
    .s_last(a_last), .frame_data(a_frame), .frame_valid(a_fv), .frame_ack(a_ack),
    .err_short(a_es), .err_long(a_el), .frame_count(a_cnt)
  );

  fcnn_frame_loader #(.dataWidth(16), .NoPixels(784), .CntWidth(2)) dut_w (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .s_last(b_last), .frame_data(b_frame), .frame_valid(b_fv), .frame_ack(b_ack),
    .err_short(b_es), .err_long(b_el), .frame_count(b_cnt)
  );

  typedef struct {
    frame_t      f;
    logic [15:0] c;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_count;
  int          n_vec = 0;
  int          n_err = 0;
  frame_t      zero_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input frame_t obs, input frame_t exp);
    int first;
    first = 0;
    n_vec++;
    assert (obs === exp) else begin
      for (int i = N_PIXELS - 1; i >= 0; i--) begin
        if (obs[i] !== exp[i]) first = i;
      end
      n_err++;
      $error("FAIL %s: pixel %0d observed %h expected %h", tag, first, obs[first], exp[first]);
    end
  endtask

  task automatic push_exp(input frame_t f, input logic [15:0] step);
    exp_t e;
    exp_count = exp_count + step;
    e.f = f;
    e.c = exp_count;
    sb.push_back(e);
  endtask

  task automatic send_beat(input bit sel, input pixel_t d, input logic last);
    if (!sel) begin a_valid = 1'b1; a_data = d; a_last = last; end
    else      begin b_valid = 1'b1; b_data = d; b_last = last; end
    @(posedge clk);
    #1;
    a_valid = 1'b0; a_last = 1'b0;
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Sends a whole well-formed frame; counts any early rise of frame_valid.
  task automatic send_frame(input bit sel, input frame_t f, input string tag);
    int early;
    early = 0;
    for (int k = 0; k < N_PIXELS; k++) begin
      send_beat(sel, f[k], k == N_PIXELS - 1);
      if (k < N_PIXELS - 1 && (sel ? b_fv : a_fv)) early++;
    end
    chk({tag, "_no_early_valid"}, early, 0);
  endtask

  // Pops the scoreboard and checks the presented frame on instance A.
  task automatic deliver_a(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, a_fv, 1);
      chk_frame({tag, "_data"}, a_frame, e.f);
      chk({tag, "_count"}, a_cnt, e.c);
      chk({tag, "_ready_low"}, a_ready, 0);
    end
  endtask

  task automatic ack_a(input string tag);
    a_ack = 1'b1;
    idle();
    a_ack = 1'b0;
    chk({tag, "_valid_drop"}, a_fv, 0);
    chk({tag, "_ready_back"}, a_ready, 1);
  endtask

  initial begin
    frame_t f;
    frame_t long_f;
    exp_t   e;
    int     bad;

    zero_f = '0;
    exp_count = '0;
    a_valid = 0; a_last = 0; a_ack = 0; a_data = '0;
    b_valid = 0; b_last = 0; b_ack = 0; b_data = '0;
    rst = 1'b1;
    #1;
    chk("rst_ready", a_ready, 0);
    chk("rst_valid", a_fv, 0);
    chk("rst_count", a_cnt, 0);
    chk("rst_errs", {a_es, a_el}, 0);
    chk_frame("rst_frame", a_frame, zero_f);
    idle();
    idle();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", a_ready, 1);

    // Nominal frame: pixel k = k.
    for (int k = 0; k < N_PIXELS; k++) f[k] = pixel_t'(k);
    push_exp(f, 1);
    send_frame(0, f, "nom");
    deliver_a("nom");

    // Backpressure: beats offered during FULL must not be taken.
    e = '{f: f, c: exp_count};
    a_valid = 1'b1; a_data = 16'hBEEF; a_last = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      idle();
      if (a_ready !== 1'b0 || a_fv !== 1'b1) bad++;
    end
    chk("bp_hold_cycles", bad, 0);
    chk_frame("bp_frame_stable", a_frame, e.f);
    chk("bp_count_stable", a_cnt, e.c);
    ack_a("bp_ack");
    for (int k = 0; k < N_PIXELS; k++) f[k] = pixel_t'(k * 3);
    f[0] = 16'hBEEF;
    push_exp(f, 1);
    send_beat(0, 16'hBEEF, 1'b0);
    for (int k = 1; k < N_PIXELS; k++) send_beat(0, f[k], k == N_PIXELS - 1);
    deliver_a("bp_next");
    ack_a("bp_next_ack");

    // Short frame: marker on beat 9.
    for (int k = 0; k < 10; k++) begin
      send_beat(0, 16'h7000 + pixel_t'(k), k == 9);
      if (k == 9) begin
        chk("short_err_pulse", a_es, 1);
        chk("short_no_long", a_el, 0);
        chk("short_no_valid", a_fv, 0);
      end
    end
    idle();
    chk("short_err_drop", a_es, 0);
    for (int k = 0; k < N_PIXELS; k++) f[k] = pixel_t'(k) ^ 16'h5A5A;
    push_exp(f, 1);
    send_frame(0, f, "after_short");
    deliver_a("after_short");
    ack_a("after_short_ack");

    // Long frame: 790 beats, marker on beat 789.
    for (int k = 0; k < N_PIXELS; k++) long_f[k] = pixel_t'(1000 + k);
    for (int k = 0; k < 790; k++) begin
      send_beat(0, pixel_t'(1000 + k), k == 789);
      if (k == 783) begin
        chk("long_err_pulse", a_el, 1);
        chk("long_no_short", a_es, 0);
      end
      if (k == 784) chk("long_err_drop", a_el, 0);
    end
    chk("long_no_valid", a_fv, 0);
    chk_frame("long_frame_kept", a_frame, long_f);
    chk("long_count", a_cnt, exp_count);
    for (int k = 0; k < N_PIXELS; k++) f[k] = pixel_t'(16'hC000 + k);
    push_exp(f, 1);
    send_frame(0, f, "after_long");
    deliver_a("after_long");
    ack_a("after_long_ack");

    // Asynchronous reset after 400 beats.
    for (int k = 0; k < 400; k++) send_beat(0, pixel_t'(16'h1234 + k), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_frame("midrst_frame", a_frame, zero_f);
    chk("midrst_ready", a_ready, 0);
    chk("midrst_count", a_cnt, 0);
    chk("midrst_valid", a_fv, 0);
    idle();
    rst = 1'b0;
    exp_count = '0;
    #1;
    for (int k = 0; k < N_PIXELS; k++) f[k] = pixel_t'(783 - k);
    push_exp(f, 1);
    send_frame(0, f, "after_rst");
    deliver_a("after_rst");
    ack_a("after_rst_ack");

    // Held ack with 2-bit counter: 1,2,3,0,1.
    b_ack = 1'b1;
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < N_PIXELS; k++) f[k] = pixel_t'(n * 100 + k);
      send_frame(1, f, "wrap");
      chk("wrap_valid", b_fv, 1);
      chk("wrap_count", b_cnt, (n + 1) % 4);
      chk_frame("wrap_data", b_frame, f);
      idle();
      chk("wrap_acked_once", b_fv, 0);
      chk("wrap_ready", b_ready, 1);
      idle();
      chk("wrap_no_second", b_fv, 0);
    end
    b_ack = 1'b0;

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
